float_normalize: RTL and testbench

FLOAT_NORMALIZE -- requirements
Module: float_normalize

---
 rtl/float_normalize_pkg.sv | 13 +
 rtl/float_normalize_if.sv | 30 +++
 rtl/float_normalize.sv | 99 +++++++++
 tb/tb_float_normalize.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_normalize_pkg.sv
// Types and default widths shared by the normalize and rounding stages.
package float_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        DONE   = 2'd2
    } norm_state_t;

    localparam int FLOAT_MANT_W = 24;
    localparam int FLOAT_EXP_W  = 8;

endpackage

// File: rtl/float_normalize_if.sv
// Operand/result handshake bundle; master drives operands and outReady, slave is the normalizer.
interface float_normalize_if
    import float_pkg::*;
#(
    parameter int n   = FLOAT_MANT_W,
    parameter int exp = FLOAT_EXP_W
);
    logic           inValid;
    logic           inReady;
    logic [n+2:0]   rawMant;
    logic [exp-1:0] rawExp;
    logic           rawSticky;
    logic [n-1:0]   normMant;
    logic [exp-1:0] normExp;
    logic           R;
    logic           S;
    logic           overflow;
    logic           outValid;
    logic           outReady;

    modport master (
        output inValid, rawMant, rawExp, rawSticky, outReady,
        input  inReady, normMant, normExp, R, S, overflow, outValid
    );

    modport slave (
        input  inValid, rawMant, rawExp, rawSticky, outReady,
        output inReady, normMant, normExp, R, S, overflow, outValid
    );
endinterface

// File: rtl/float_normalize.sv
// Iterative mantissa normalizer: one shift per cycle until hidden bit set, zero, or denormal.
// Latency: 2 cycles normalized, 3 on carry, 2+k for k left shifts (accept edge counted as 1).
// Backpressure: result held in DONE until outReady; inReady only in IDLE.
module float_normalize
    import float_pkg::*;
#(
    parameter int n   = FLOAT_MANT_W,
    parameter int exp = FLOAT_EXP_W
) (
    input  logic              Clock,
    input  logic              Reset,
    float_normalize_if.slave  bus
);

    localparam logic [exp-1:0] EXP_MAX = '1;
    localparam logic [exp-1:0] EXP_ONE = {{(exp-1){1'b0}}, 1'b1};

    norm_state_t    state, state_nxt;
    logic [n+2:0]   work, work_nxt;
    logic [exp-1:0] expReg, exp_nxt;
    logic           stk, stk_nxt;
    logic           ovf, ovf_nxt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            work   <= '0;
            expReg <= '0;
            stk    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            expReg <= exp_nxt;
            stk    <= stk_nxt;
            ovf    <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        exp_nxt   = expReg;
        stk_nxt   = stk;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (bus.inValid) begin
                    work_nxt  = bus.rawMant;
                    exp_nxt   = bus.rawExp;
                    stk_nxt   = bus.rawSticky;
                    ovf_nxt   = 1'b0;
                    state_nxt = ADJUST;
                end
            end
            ADJUST: begin
                if (work[n+2]) begin
                    stk_nxt = stk | work[0];
                    // An exponent already at max also saturates rather than wrapping.
                    if (expReg >= EXP_MAX - EXP_ONE) begin
                        ovf_nxt   = 1'b1;
                        work_nxt  = '0;
                        exp_nxt   = EXP_MAX;
                        state_nxt = DONE;
                    end else begin
                        work_nxt = work >> 1;
                        exp_nxt  = expReg + EXP_ONE;
                    end
                end else if (work == '0) begin
                    exp_nxt   = '0;
                    state_nxt = DONE;
                end else if (work[n+1]) begin
                    state_nxt = DONE;
                end else if (expReg <= EXP_ONE) begin
                    exp_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    work_nxt = work << 1;
                    exp_nxt  = expReg - EXP_ONE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.inReady  = (state == IDLE);
    assign bus.outValid = (state == DONE);
    assign bus.normMant = work[n+1:2];
    assign bus.normExp  = expReg;
    assign bus.R        = work[1];
    assign bus.S        = work[0] | stk;
    assign bus.overflow = ovf;

endmodule

// File: tb/tb_float_normalize.sv
// Randomized bench for float_normalize against a closed-form reference model.
module tb_float_normalize;

    localparam int N = 24;
    localparam int E = 8;
    localparam int W = N + 3;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    float_normalize_if #(.n(N), .exp(E)) bus();

    float_normalize #(.n(N), .exp(E)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0] mant;
        int           e;
        bit           r;
        bit           s;
        bit           ovf;
        int           lat;
        int           acc;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold = 1'b0;
    bit   lat_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result follows from the leading-one position and the available exponent headroom.
    function automatic res_t model(input logic [W-1:0] m_in, input int e_in, input bit s_in);
        res_t         r;
        logic [W-1:0] m;
        int           ee, p, need, avail, k;
        m = m_in; ee = e_in; r.s = s_in; r.lat = 1; r.ovf = 1'b0; r.acc = 0;
        if (m[W-1]) begin
            r.s = r.s | m[0];
            m = m >> 1;
            ee = ee + 1;
            r.lat++;
            if (ee >= (1 << E) - 1) begin
                r.mant = '0; r.e = (1 << E) - 1; r.r = 1'b0; r.ovf = 1'b1;
                return r;
            end
        end
        if (m == '0) begin
            ee = 0;
            r.lat++;
        end else begin
            p = 0;
            for (int i = 0; i < W; i++) if (m[i]) p = i;
            need  = (W - 2) - p;
            avail = (ee > 1) ? ee - 1 : 0;
            k     = (need < avail) ? need : avail;
            m     = m << k;
            ee    = ee - k;
            r.lat = r.lat + k + 1;
            if (k < need) ee = 0;
        end
        r.mant = m[W-2:2];
        r.e    = ee;
        r.r    = m[1];
        r.s    = r.s | m[0];
        return r;
    endfunction

    always @(posedge Clock) begin
        res_t r;
        if (Reset) begin
            q.delete();
            lat_done = 1'b0;
        end else begin
            if (bus.outValid && bus.outReady && q.size() > 0) begin
                void'(q.pop_front());
                lat_done = 1'b0;
            end
            if (bus.inValid && bus.inReady) begin
                r = model(bus.rawMant, int'(bus.rawExp), bus.rawSticky);
                r.acc = cyc;
                q.push_back(r);
            end
        end
        cyc++;
    end

    always @(negedge Clock) begin
        if (!Reset && bus.outValid) begin
            if (q.size() == 0) begin
                chk("unexpected_outValid", 64'd1, 64'd0);
            end else begin
                chk("normMant", 64'(bus.normMant), 64'(q[0].mant));
                chk("normExp",  64'(bus.normExp),  64'(q[0].e));
                chk("R",        64'(bus.R),        64'(q[0].r));
                chk("S",        64'(bus.S),        64'(q[0].s));
                chk("overflow", 64'(bus.overflow), 64'(q[0].ovf));
                chk("inReady_in_DONE", 64'(bus.inReady), 64'd0);
                if (!lat_done) begin
                    chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                    lat_done = 1'b1;
                end
            end
        end
    end

    initial begin
        bus.outReady = 1'b0;
        forever begin
            @(negedge Clock);
            bus.outReady = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] m, input logic [E-1:0] e, input bit s);
        bit got;
        got = 1'b0;
        @(negedge Clock);
        bus.inValid   = 1'b1;
        bus.rawMant   = m;
        bus.rawExp    = e;
        bus.rawSticky = s;
        for (int t = 0; t < 400 && !got; t++) begin
            if (t > 0) @(negedge Clock);
            got = bus.inReady;
            @(posedge Clock);
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        @(negedge Clock);
        bus.inValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge Clock);
            ok = (q.size() == 0) && bus.inReady;
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic pin(input string name, input res_t got, input logic [N-1:0] mant,
                       input int e, input bit r, input bit s, input bit ovf, input int lat);
        chk({name, "_mant"}, 64'(got.mant), 64'(mant));
        chk({name, "_exp"},  64'(got.e),    64'(e));
        chk({name, "_R"},    64'(got.r),    64'(r));
        chk({name, "_S"},    64'(got.s),    64'(s));
        chk({name, "_ovf"},  64'(got.ovf),  64'(ovf));
        chk({name, "_lat"},  64'(got.lat),  64'(lat));
    endtask

    initial begin
        logic [W-1:0] m, rnd;
        logic [E-1:0] e;
        int           sel, p;
        bit           ok;

        bus.inValid = 1'b0; bus.rawMant = '0; bus.rawExp = '0; bus.rawSticky = 1'b0;

        pin("model_norm",  model(27'h2000003, 127, 1'b0), 24'h800000, 127, 1'b1, 1'b1, 1'b0, 2);
        pin("model_carry", model(27'h4000001, 100, 1'b0), 24'h800000, 101, 1'b0, 1'b1, 1'b0, 3);
        pin("model_shift", model(27'h0000004, 127, 1'b0), 24'h800000, 104, 1'b0, 1'b0, 1'b0, 25);
        pin("model_denorm", model(27'h0000100, 3, 1'b0), 24'h000100, 0, 1'b0, 1'b0, 1'b0, 4);
        pin("model_ovf",   model(27'h4000000, 254, 1'b0), 24'h000000, 255, 1'b0, 1'b0, 1'b1, 2);

        repeat (3) @(negedge Clock);
        chk("rst_outValid", 64'(bus.outValid), 64'd0);
        chk("rst_inReady",  64'(bus.inReady),  64'd1);
        chk("rst_normMant", 64'(bus.normMant), 64'd0);
        chk("rst_normExp",  64'(bus.normExp),  64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_S",        64'(bus.S),        64'd0);
        Reset = 1'b0;

        send(27'h2000003, 8'd127, 1'b0);
        send(27'h4000001, 8'd100, 1'b0);
        send(27'h0000004, 8'd127, 1'b0);
        send(27'h0000100, 8'd3,   1'b0);
        send(27'h0000000, 8'd50,  1'b1);
        send(27'h4000000, 8'd254, 1'b0);
        send(27'h4000001, 8'd255, 1'b1);
        send(27'h0000001, 8'd1,   1'b0);
        wait_idle();

        // Result must sit unchanged while downstream stalls.
        hold = 1'b1;
        send(27'h2000003, 8'd127, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge Clock);
            ok = bus.outValid;
        end
        if (!ok) chk("hold_outValid_timeout", 64'd0, 64'd1);
        for (int t = 0; t < 5; t++) begin
            @(negedge Clock);
            chk("hold_outValid", 64'(bus.outValid), 64'd1);
            chk("hold_inReady",  64'(bus.inReady),  64'd0);
        end
        hold = 1'b0;
        wait_idle();

        // Abort a long left-shift mid-flight.
        send(27'h0000004, 8'd127, 1'b0);
        repeat (5) @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("abort_outValid", 64'(bus.outValid), 64'd0);
        chk("abort_inReady",  64'(bus.inReady),  64'd1);
        chk("abort_overflow", 64'(bus.overflow), 64'd0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (30) @(negedge Clock);
        chk("after_abort_inReady", 64'(bus.inReady), 64'd1);

        for (int i = 0; i < 300; i++) begin
            rnd = W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) m = '0;
            else if (sel <= 2) m = rnd | (W'(1) << (W - 1));
            else begin
                p = $urandom_range(0, W - 2);
                m = (W'(1) << p) | (rnd & ((W'(1) << p) - W'(1)));
            end
            e = ($urandom_range(0, 1) != 0) ? E'($urandom_range(0, 255)) : E'($urandom_range(0, 30));
            send(m, e, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 6)) @(negedge Clock);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
